// File: rtl/fm_window_reader.sv
// fm_window_reader: parallel read-address generator for an N-bank line buffer feeding a KxK window.
// Each bank keeps a running slot base so the per-beat address is a single add.
module fm_window_reader #(
    parameter int NUM_BANKS  = 3,
    parameter int ADDR_W     = 11,
    parameter int DIM_W      = 9,
    parameter int SLOTS      = 1,
    parameter int RD_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    input  logic [DIM_W-1:0]             fm_width,
    input  logic [DIM_W-1:0]             fm_height,
    input  logic                         rd_ready,
    output logic [NUM_BANKS-1:0]         ram_ren,
    output logic [NUM_BANKS*ADDR_W-1:0]  ram_addr,
    output logic                         win_valid,
    output logic [$clog2(NUM_BANKS)-1:0] win_rot,
    output logic [DIM_W-1:0]             win_col,
    output logic                         win_last,
    output logic                         busy,
    output logic                         done,
    output logic                         cfg_err
);
    localparam int RW = $clog2(NUM_BANKS);
    localparam int L  = RD_LATENCY;

    typedef enum logic [1:0] {IDLE, CHECK, RUN, DRAIN} state_t;

    state_t                      state_q, state_d;
    logic [DIM_W-1:0]            w_q, w_d, h_q, h_d, x_q, x_d, y_q, y_d;
    logic [RW-1:0]               rot_q, rot_d;
    logic [31:0]                 lim_q, lim_d;
    logic [ADDR_W-1:0]           base_q [NUM_BANKS];
    logic [ADDR_W-1:0]           base_d [NUM_BANKS];
    logic                        ren_q, ren_d;
    logic [NUM_BANKS*ADDR_W-1:0] addr_q, addr_d;
    logic [RW-1:0]               m_rot_q, m_rot_d;
    logic [DIM_W-1:0]            m_col_q, m_col_d;
    logic                        m_last_q, m_last_d;
    logic [L-1:0]                pv_q, pv_d, pl_q, pl_d;
    logic [RW-1:0]               pr_q [L];
    logic [RW-1:0]               pr_d [L];
    logic [DIM_W-1:0]            pc_q [L];
    logic [DIM_W-1:0]            pc_d [L];
    logic                        done_q, done_d, err_q, err_d;
    logic                        fire, x_end, y_end;
    logic [ADDR_W:0]             nb;
    logic [31:0]                 lim_full;

    always_comb begin
        x_end    = x_q == w_q - DIM_W'(1);
        y_end    = y_q == h_q - DIM_W'(NUM_BANKS);
        fire     = state_q == RUN && rd_ready && !abort;
        nb       = {1'b0, base_q[rot_q]} + (ADDR_W+1)'(w_q);
        lim_full = 32'(SLOTS) * 32'(w_q);
        state_d  = state_q;
        w_d      = w_q;
        h_d      = h_q;
        x_d      = x_q;
        y_d      = y_q;
        rot_d    = rot_q;
        lim_d    = lim_q;
        base_d   = base_q;
        err_d    = err_q;
        done_d   = 1'b0;
        ren_d    = fire;
        m_rot_d  = fire ? rot_q : '0;
        m_col_d  = fire ? x_q : '0;
        m_last_d = fire && x_end && y_end;
        addr_d   = addr_q;
        for (int b = 0; b < NUM_BANKS; b++)
            if (fire) addr_d[b*ADDR_W +: ADDR_W] = base_q[b] + ADDR_W'(x_q);
        // RAM returns data L cycles after ren; sideband rides a matching shift chain
        pv_d     = L'({pv_q, ren_q});
        pl_d     = L'({pl_q, m_last_q});
        pr_d[0]  = m_rot_q;
        pc_d[0]  = m_col_q;
        for (int i = 1; i < L; i++) begin
            pr_d[i] = pr_q[i-1];
            pc_d[i] = pc_q[i-1];
        end
        if (abort) begin
            state_d = IDLE;
            pv_d    = '0;
            pl_d    = '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    w_d     = fm_width;
                    h_d     = fm_height;
                    err_d   = 1'b0;
                    state_d = CHECK;
                end
                CHECK: if (w_q == '0 || h_q < DIM_W'(NUM_BANKS) || lim_full > (32'd1 << ADDR_W)) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    x_d     = '0;
                    y_d     = '0;
                    rot_d   = '0;
                    lim_d   = lim_full;
                    for (int b = 0; b < NUM_BANKS; b++) base_d[b] = '0;
                    state_d = RUN;
                end
                RUN: if (fire) begin
                    x_d = x_end ? '0 : x_q + DIM_W'(1);
                    if (x_end && y_end) state_d = DRAIN;
                    else if (x_end) begin
                        // the bank holding the departing top row takes the next incoming row
                        y_d           = y_q + DIM_W'(1);
                        rot_d         = rot_q == RW'(NUM_BANKS - 1) ? '0 : rot_q + RW'(1);
                        base_d[rot_q] = 32'(nb) >= lim_q ? '0 : nb[ADDR_W-1:0];
                    end
                end
                DRAIN: if (pv_d == '0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            w_q      <= '0;
            h_q      <= '0;
            x_q      <= '0;
            y_q      <= '0;
            rot_q    <= '0;
            lim_q    <= '0;
            ren_q    <= 1'b0;
            addr_q   <= '0;
            m_rot_q  <= '0;
            m_col_q  <= '0;
            m_last_q <= 1'b0;
            pv_q     <= '0;
            pl_q     <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            for (int b = 0; b < NUM_BANKS; b++) base_q[b] <= '0;
            for (int i = 0; i < L; i++) begin
                pr_q[i] <= '0;
                pc_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            w_q      <= w_d;
            h_q      <= h_d;
            x_q      <= x_d;
            y_q      <= y_d;
            rot_q    <= rot_d;
            lim_q    <= lim_d;
            ren_q    <= ren_d;
            addr_q   <= addr_d;
            m_rot_q  <= m_rot_d;
            m_col_q  <= m_col_d;
            m_last_q <= m_last_d;
            pv_q     <= pv_d;
            pl_q     <= pl_d;
            done_q   <= done_d;
            err_q    <= err_d;
            base_q   <= base_d;
            pr_q     <= pr_d;
            pc_q     <= pc_d;
        end
    end

    assign ram_ren   = {NUM_BANKS{ren_q}};
    assign ram_addr  = addr_q;
    assign win_valid = pv_q[L-1];
    assign win_rot   = pr_q[L-1];
    assign win_col   = pc_q[L-1];
    assign win_last  = pl_q[L-1];
    assign busy      = state_q != IDLE || ren_q || (|pv_q);
    assign done      = done_q;
    assign cfg_err   = err_q;
endmodule

// File: tb/tb_fm_window_reader.sv
// tb_fm_window_reader: directed checks of the window read-address generator across four parameter sets.
module tb_fm_window_reader;
    localparam int N = 3;

    logic        clk = 1'b0, rst_n = 1'b0, abort = 1'b0, rd_ready = 1'b0;
    logic [8:0]  fm_width = '0, fm_height = '0;
    logic [3:0]  start = '0;
    logic [2:0]  ren [4];
    logic [32:0] addr_a, addr_b, addr_d;
    logic [8:0]  addr_c;
    logic        valid [4];
    logic        last [4];
    logic        busy [4];
    logic        done [4];
    logic        err [4];
    logic [1:0]  rot [4];
    logic [8:0]  col [4];
    int          checks = 0, errors = 0, sel = 0;

    logic [2:0]  o_ren;
    logic [32:0] o_addr;
    logic        o_valid, o_last, o_busy, o_done, o_err;
    logic [1:0]  o_rot;
    logic [8:0]  o_col;

    always #5 clk = ~clk;

    fm_window_reader dut_a (.clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort), .fm_width(fm_width),
        .fm_height(fm_height), .rd_ready(rd_ready), .ram_ren(ren[0]), .ram_addr(addr_a), .win_valid(valid[0]),
        .win_rot(rot[0]), .win_col(col[0]), .win_last(last[0]), .busy(busy[0]), .done(done[0]), .cfg_err(err[0]));
    fm_window_reader #(.SLOTS(2)) dut_b (.clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort),
        .fm_width(fm_width), .fm_height(fm_height), .rd_ready(rd_ready), .ram_ren(ren[1]), .ram_addr(addr_b),
        .win_valid(valid[1]), .win_rot(rot[1]), .win_col(col[1]), .win_last(last[1]), .busy(busy[1]),
        .done(done[1]), .cfg_err(err[1]));
    fm_window_reader #(.ADDR_W(3), .SLOTS(2)) dut_c (.clk(clk), .rst_n(rst_n), .start(start[2]), .abort(abort),
        .fm_width(fm_width), .fm_height(fm_height), .rd_ready(rd_ready), .ram_ren(ren[2]), .ram_addr(addr_c),
        .win_valid(valid[2]), .win_rot(rot[2]), .win_col(col[2]), .win_last(last[2]), .busy(busy[2]),
        .done(done[2]), .cfg_err(err[2]));
    fm_window_reader #(.RD_LATENCY(2)) dut_d (.clk(clk), .rst_n(rst_n), .start(start[3]), .abort(abort),
        .fm_width(fm_width), .fm_height(fm_height), .rd_ready(rd_ready), .ram_ren(ren[3]), .ram_addr(addr_d),
        .win_valid(valid[3]), .win_rot(rot[3]), .win_col(col[3]), .win_last(last[3]), .busy(busy[3]),
        .done(done[3]), .cfg_err(err[3]));

    always_comb begin
        o_ren   = ren[sel];
        o_valid = valid[sel];
        o_last  = last[sel];
        o_busy  = busy[sel];
        o_done  = done[sel];
        o_err   = err[sel];
        o_rot   = rot[sel];
        o_col   = col[sel];
        o_addr  = sel == 0 ? addr_a : sel == 1 ? addr_b : sel == 2 ? 33'(addr_c) : addr_d;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_frame(input string nm, input int s, input int w, input int h, input int slots,
                             input int lat, input int pat, input int abort_beat, input int mid_start);
        int beats, issued, got, last_t, rb, k;
        int rt[$];
        bit rdy, seen_done, ev;
        logic [32:0] ea;
        beats = w * (h - N + 1);
        issued = 0;
        got = 0;
        last_t = -100;
        seen_done = 0;
        sel = s;
        fm_width = 9'(w);
        fm_height = 9'(h);
        start[s] = 1'b1;
        tick();
        start[s] = 1'b0;
        chk({nm, ":busy_after_start"}, o_busy, 1);
        chk({nm, ":cfg_err_clear"}, o_err, 0);
        for (int c = 0; c < 300 && !seen_done; c++) begin
            rdy = pat == 0 ? 1'b1 : (c % 4 == 0 || c % 4 == 3);
            rd_ready = rdy;
            start[s] = mid_start != 0 && c == 4;
            tick();
            chk({nm, ":ren"}, o_ren, (c >= 1 && rdy && issued < beats) ? 3'b111 : 3'b000);
            if (o_ren != 0) begin
                ea = '0;
                for (int b = 0; b < N; b++) begin
                    rb = issued / w + (((b - issued / w) % N) + N) % N;
                    ea[b*11 +: 11] = 11'(((rb / N) % slots) * w + issued % w);
                end
                chk({nm, ":addr"}, o_addr, ea);
                rt.push_back(c);
                issued++;
                if (abort_beat == issued) begin
                    abort = 1'b1;
                    tick();
                    abort = 1'b0;
                    chk({nm, ":abort_ren"}, o_ren, 0);
                    chk({nm, ":abort_valid"}, o_valid, 0);
                    for (int i = 0; i < 5; i++) begin
                        tick();
                        chk({nm, ":abort_no_done"}, o_done, 0);
                        chk({nm, ":abort_no_ren"}, o_ren, 0);
                    end
                    chk({nm, ":abort_busy"}, o_busy, 0);
                    rd_ready = 1'b0;
                    return;
                end
            end
            ev = rt.size() > 0 && rt[0] + lat == c;
            chk({nm, ":win_valid"}, o_valid, ev);
            if (ev) begin
                k = got;
                void'(rt.pop_front());
                chk({nm, ":win_rot"}, o_rot, (k / w) % N);
                chk({nm, ":win_col"}, o_col, k % w);
                chk({nm, ":win_last"}, o_last, k == beats - 1);
                got++;
                if (got == beats) last_t = c;
            end
            chk({nm, ":done"}, o_done, got == beats && c == last_t + 1);
            if (o_done) begin
                chk({nm, ":busy_at_done"}, o_busy, 0);
                chk({nm, ":beats"}, got, beats);
                seen_done = 1;
            end
        end
        rd_ready = 1'b0;
        start[s] = 1'b0;
        chk({nm, ":done_seen"}, seen_done, 1);
    endtask

    task automatic cfg_case(input string nm, input int s, input int w, input int h, input bit exp_err);
        sel = s;
        rd_ready = 1'b0;
        fm_width = 9'(w);
        fm_height = 9'(h);
        start[s] = 1'b1;
        tick();
        start[s] = 1'b0;
        chk({nm, ":check_done"}, o_done, 0);
        chk({nm, ":check_busy"}, o_busy, 1);
        chk({nm, ":check_err_clear"}, o_err, 0);
        tick();
        chk({nm, ":done"}, o_done, exp_err);
        chk({nm, ":cfg_err"}, o_err, exp_err);
        chk({nm, ":no_ren"}, o_ren, 0);
        tick();
        chk({nm, ":done_pulse"}, o_done, 0);
        chk({nm, ":cfg_err_sticky"}, o_err, exp_err);
        chk({nm, ":busy"}, o_busy, !exp_err);
        chk({nm, ":no_ren2"}, o_ren, 0);
        if (!exp_err) begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
            chk({nm, ":abort_idle"}, o_busy, 0);
        end
    endtask

    initial begin
        #12;
        for (int s = 0; s < 4; s++) begin
            sel = s;
            #0;
            chk("reset:ren", o_ren, 0);
            chk("reset:addr", o_addr, 0);
            chk("reset:valid", o_valid, 0);
            chk("reset:busy", o_busy, 0);
            chk("reset:done", o_done, 0);
            chk("reset:cfg_err", o_err, 0);
        end
        rst_n = 1'b1;
        tick();
        run_frame("s1", 0, 4, 5, 1, 1, 0, -1, 0);
        run_frame("slots2", 1, 4, 7, 2, 1, 0, -1, 0);
        run_frame("ready_toggle", 0, 4, 5, 1, 1, 1, -1, 0);
        cfg_case("h2", 0, 4, 2, 1'b1);
        cfg_case("w0", 0, 0, 5, 1'b1);
        cfg_case("addr_overflow", 2, 5, 5, 1'b1);
        cfg_case("addr_fits", 2, 4, 5, 1'b0);
        run_frame("abort", 0, 4, 5, 1, 1, 0, 6, 0);
        run_frame("after_abort", 0, 4, 5, 1, 1, 0, -1, 0);
        run_frame("lat2", 3, 4, 5, 1, 2, 0, -1, 1);
        sel = 0;
        fm_width = 9'd4;
        fm_height = 9'd5;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        rd_ready = 1'b1;
        repeat (4) tick();
        chk("arst:ren_before", o_ren, 3'b111);
        #2 rst_n = 1'b0;
        #1;
        chk("arst:ren", o_ren, 0);
        chk("arst:addr", o_addr, 0);
        chk("arst:busy", o_busy, 0);
        #2 rst_n = 1'b1;
        rd_ready = 1'b0;
        tick();
        chk("arst:idle", o_busy, 0);
        run_frame("after_arst", 0, 4, 5, 1, 1, 0, -1, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
